// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO in front of the UART transmit engine. The CPU write port pushes
//   bytes back-to-back; a small drain FSM hands them to the TX engine one at a
//   time with a load/ready handshake, so software never polls tx_rdy per byte.
//
// Ports
//   i_clock         system clock
//   i_reset         synchronous, active-high reset
//   i_wr_en         push i_wr_data this cycle
//   i_wr_data       byte to transmit
//   i_clr_ovf       clears the sticky overflow flag
//   i_tx_rdy        TX engine idle (high = can accept a load)
//   o_tx_load       one-cycle load pulse to the TX engine
//   o_tx_load_data  byte presented with o_tx_load, held until the next load
//   o_full          occupancy == DEPTH
//   o_empty         occupancy == 0
//   o_count         occupancy, 0..DEPTH
//   o_ovf           sticky: a push was dropped because the FIFO was full
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_wr_en,
   input  logic [7:0]    i_wr_data,
   input  logic          i_clr_ovf,
   input  logic          i_tx_rdy,
   output logic          o_tx_load,
   output logic [7:0]    o_tx_load_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count,
   output logic          o_ovf
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_RDY} state_t;

   state_t         r_state, w_state_nxt;
   logic [7:0]     r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [AW:0]    r_count, w_count_nxt;
   logic           r_full, r_empty, r_ovf;
   logic [7:0]     r_tx_data;
   logic           w_pop, w_push;

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push
   // when the drain side is popping.
   assign w_pop  = (r_state == S_IDLE) && !r_empty && i_tx_rdy;
   assign w_push = i_wr_en && (!r_full || w_pop);

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + (AW+1)'(1);
      else if (w_pop && !w_push) w_count_nxt = r_count - (AW+1)'(1);
   end

   // Storage array carries no reset; only pointers and flags define validity.
   always_ff @(posedge i_clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_ovf     <= 1'b0;
         r_tx_data <= 8'h00;
         r_state   <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == LP_DEPTH);
         r_empty <= (w_count_nxt == '0);
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + AW'(1);
            r_tx_data <= r_mem[r_rd_ptr];
         end
         // A dropped push wins over a simultaneous clear.
         if (i_wr_en && r_full && !w_pop) r_ovf <= 1'b1;
         else if (i_clr_ovf)              r_ovf <= 1'b0;
      end
   end

   // Drain FSM: LOAD lasts one cycle, then track the engine's ready going
   // low (frame accepted) and high again (frame done) before the next pop.
   always_comb begin
      w_state_nxt = r_state;
      o_tx_load   = 1'b0;
      case (r_state)
         S_IDLE:      if (w_pop) w_state_nxt = S_LOAD;
         S_LOAD: begin
            o_tx_load   = 1'b1;
            w_state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: if (!i_tx_rdy) w_state_nxt = S_WAIT_RDY;
         S_WAIT_RDY:  if (i_tx_rdy)  w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   assign o_tx_load_data = r_tx_data;
   assign o_full         = r_full;
   assign o_empty        = r_empty;
   assign o_count        = r_count;
   assign o_ovf          = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Scoreboard bench for uart_tx_fifo. Stimulus pushes expected bytes into a
//   queue; a monitor pops and compares on every tx_load. A small TX engine
//   model drops ready after each load for a random frame length; 'hold'
//   forces ready low so the FIFO can be filled.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst, wr_en, clr_ovf, hold, eng_rdy;
   logic [7:0]    wr_data;
   logic          tx_rdy;
   logic          tx_load;
   logic [7:0]    tx_load_data;
   logic          full, empty, ovf;
   logic [AW:0]   count;

   int            checks = 0, errors = 0;
   int            n_acc = 0, n_load = 0;
   logic [7:0]    exp_q[$];
   logic          prev_load;
   int            busy;

   assign tx_rdy = eng_rdy && !hold;

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .i_clock(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
      .i_clr_ovf(clr_ovf), .i_tx_rdy(tx_rdy), .o_tx_load(tx_load),
      .o_tx_load_data(tx_load_data), .o_full(full), .o_empty(empty),
      .o_count(count), .o_ovf(ovf));

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Called at a negedge; drives one push for one cycle.
   task automatic push(input logic [7:0] d, input bit accepted);
      wr_en   = 1'b1;
      wr_data = d;
      if (accepted) begin
         exp_q.push_back(d);
         n_acc++;
      end
      step();
      wr_en = 1'b0;
   endtask

   task automatic chk_status(input string tag);
      int exp_cnt;
      exp_cnt = n_acc - n_load;
      check({tag, "_count"}, 32'(count), 32'(exp_cnt));
      check({tag, "_empty"}, 32'(empty), 32'(exp_cnt == 0));
      check({tag, "_full"},  32'(full),  32'(exp_cnt == DEPTH));
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      repeat (10) step();
   endtask

   // TX engine: ready falls the cycle after a load, stays low for a random
   // frame length, then rises.
   initial begin
      eng_rdy = 1'b1;
      busy    = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            eng_rdy = 1'b1;
            busy    = 0;
         end else if (tx_load) begin
            eng_rdy = 1'b0;
            busy    = $urandom_range(1, 4);
         end else if (busy > 0) begin
            busy--;
         end else begin
            eng_rdy = 1'b1;
         end
      end
   end

   // Monitor / scoreboard consumer.
   initial begin
      prev_load = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tx_load) begin
            check("no_b2b_load", 32'(prev_load), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_load: got data %0h expected no load", tx_load_data);
            end else begin
               check("tx_data", 32'(tx_load_data), 32'(exp_q.pop_front()));
               n_load++;
            end
         end
         prev_load = tx_load;
      end
   end

   initial begin
      int pushed;
      rst = 1'b1; wr_en = 1'b0; clr_ovf = 1'b0; hold = 1'b0; wr_data = 8'h00;
      repeat (3) step();
      // reset state
      check("rst_load", 32'(tx_load), 32'd0);
      check("rst_data", 32'(tx_load_data), 32'h00);
      check("rst_ovf",  32'(ovf), 32'd0);
      chk_status("rst");
      rst = 1'b0;
      step();

      // 1: single byte, latency
      push(8'hA5, 1'b1);
      check("t1_load_early", 32'(tx_load), 32'd0);
      check("t1_empty_mid",  32'(empty), 32'd0);
      step();
      check("t1_load",  32'(tx_load), 32'd1);
      check("t1_data",  32'(tx_load_data), 32'hA5);
      check("t1_empty", 32'(empty), 32'd1);
      repeat (10) step();

      // 2: fill while engine held busy
      hold = 1'b1;
      for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b1);
      chk_status("t2");
      check("t2_ovf", 32'(ovf), 32'd0);

      // 3: overflow; set beats simultaneous clear, then clear alone
      clr_ovf = 1'b1;
      push(8'hFF, 1'b0);
      clr_ovf = 1'b0;
      check("t3_ovf_set_prio", 32'(ovf), 32'd1);
      chk_status("t3");
      push(8'hFE, 1'b0);
      check("t3_ovf_sticky", 32'(ovf), 32'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("t3_ovf_clr", 32'(ovf), 32'd0);

      // 4: push into full FIFO in the cycle the first pop happens
      hold = 1'b0;
      push(8'h77, 1'b1);
      chk_status("t4");
      check("t4_ovf", 32'(ovf), 32'd0);
      wait_drain("t4");
      chk_status("t4_end");

      // 5: reset in WAIT_RDY with 5 bytes queued
      hold = 1'b1;
      for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i), 1'b1);
      hold = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tx_load) break;
      end
      check("t5_load_seen", 32'(tx_load), 32'd1);
      hold = 1'b1;
      step();
      step();
      chk_status("t5_pre");
      rst = 1'b1;
      exp_q.delete();
      n_acc  = 0;
      n_load = 0;
      step();
      rst = 1'b0;
      chk_status("t5_rst");
      check("t5_rst_load", 32'(tx_load), 32'd0);
      hold = 1'b0;
      repeat (20) step();
      chk_status("t5_quiet");
      push(8'h3C, 1'b1);
      wait_drain("t5_after");

      // 6: random traffic across pointer wrap
      pushed = 0;
      for (int it = 0; it < 3000 && pushed < 40; it++) begin
         hold = ($urandom_range(0, 3) == 0);
         if ((n_acc - n_load) < DEPTH && $urandom_range(0, 2) != 0) begin
            push(8'($urandom), 1'b1);
            pushed++;
         end else begin
            step();
         end
         chk_status("t6");
      end
      check("t6_pushed", 32'(pushed), 32'd40);
      hold = 1'b0;
      wait_drain("t6");
      chk_status("t6_end");
      check("t6_loads", 32'(n_load), 32'(n_acc));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
